// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache-line to burst-memory adapter.
package mem_types;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned BEATS    = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_COLLECT,
    WR_BURST,
    RESP
  } adapter_state_t;

  // Clears the byte-within-line offset bits.
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side (dfp_*) and memory-side (bmem_*) signals of the adapter.
// master: the cache plus burst memory around the adapter; slave: the adapter.
interface cacheline_adapter_if;
  import mem_types::*;

  logic [31:0] dfp_addr;
  logic        dfp_read;
  logic        dfp_write;
  line_t       dfp_wdata;
  line_t       dfp_rdata;
  logic        dfp_resp;

  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  beat_t       bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  beat_t       bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/cacheline_adapter_buffer.sv
// Line register with a beat-indexed fill port for reads and a beat-indexed
// read mux for write draining; the beat index comes from the adapter FSM.
module line_shift_buffer #(
  parameter  int unsigned LINE_W = 256,
  parameter  int unsigned BEAT_W = 64,
  parameter  int unsigned BEATS  = 4,
  localparam int unsigned IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              fill,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [BEAT_W-1:0] fill_beat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [LINE_W-1:0] line_next
);

  logic [LINE_W-1:0] line_q;

  // line_next already contains the beat being filled this cycle, so the last
  // beat can be published without waiting for it to land in line_q.
  always_comb begin
    line_next = line_q;
    if (fill)
      line_next[fill_idx*BEAT_W +: BEAT_W] = fill_beat;
  end

  assign rd_beat = line_q[rd_idx*BEAT_W +: BEAT_W];

  always_ff @(posedge clk) begin
    if (!rst)
      line_q <= '0;
    else if (load)
      line_q <= load_line;
    else if (fill)
      line_q <= line_next;
  end

endmodule

// File: rtl/cacheline_adapter.sv
// Converts single-transfer 256-bit cache line requests into 4-beat 64-bit
// memory bursts, one line transaction outstanding at a time.
module cacheline_adapter #(
  parameter int unsigned LINE_W = mem_types::LINE_W,
  parameter int unsigned BEAT_W = mem_types::BEAT_W,
  parameter int unsigned BEATS  = mem_types::BEATS
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);
  import mem_types::adapter_state_t;
  import mem_types::line_base;
  import mem_types::IDLE;
  import mem_types::RD_ISSUE;
  import mem_types::RD_COLLECT;
  import mem_types::WR_BURST;
  import mem_types::RESP;

  localparam int unsigned     CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  adapter_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rd_idx;
  logic [31:0]       addr_q;
  logic              beat_hit;
  logic              load_line;
  logic [BEAT_W-1:0] rd_beat;
  logic [LINE_W-1:0] line_next;

  assign beat_hit  = (state == RD_COLLECT) && bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
  assign load_line = (state == IDLE) && bus.dfp_write;
  // bmem_wdata is registered, so the mux looks one beat ahead of cnt.
  assign rd_idx    = cnt + CNT_W'(1);
  assign bus.bmem_addr = addr_q;

  line_shift_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_line),
    .load_line (bus.dfp_wdata),
    .fill      (beat_hit),
    .fill_idx  (cnt),
    .fill_beat (bus.bmem_rdata),
    .rd_idx    (rd_idx),
    .rd_beat   (rd_beat),
    .line_next (line_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      bus.dfp_resp   <= 1'b0;
      bus.dfp_rdata  <= '0;
      bus.bmem_read  <= 1'b0;
      bus.bmem_write <= 1'b0;
      bus.bmem_wdata <= '0;
    end else begin
      bus.dfp_resp <= 1'b0;
      case (state)
        IDLE: begin
          addr_q <= line_base(bus.dfp_addr);
          cnt    <= '0;
          if (bus.dfp_write) begin
            state          <= WR_BURST;
            bus.bmem_write <= 1'b1;
            bus.bmem_wdata <= bus.dfp_wdata[BEAT_W-1:0];
          end else if (bus.dfp_read) begin
            state         <= RD_ISSUE;
            bus.bmem_read <= 1'b1;
          end
        end
        RD_ISSUE: begin
          if (bus.bmem_ready) begin
            bus.bmem_read <= 1'b0;
            state         <= RD_COLLECT;
          end
        end
        RD_COLLECT: begin
          if (beat_hit) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              bus.dfp_rdata <= line_next;
              bus.dfp_resp  <= 1'b1;
              state         <= RESP;
            end
          end
        end
        WR_BURST: begin
          if (bus.bmem_ready) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              bus.bmem_write <= 1'b0;
              bus.dfp_resp   <= 1'b1;
              state          <= RESP;
            end else begin
              bus.bmem_wdata <= rd_beat;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Downstream neighbour of the data cache: converts the cache's single-transfer 256-bit line port (dfp_*) into a 4-beat, 64-bit burst memory protocol (bmem_*).
- Reads collect 4 returned beats into one line. Writes serialise one line into 4 beats.
- Exactly one outstanding line transaction at a time.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, burst beat width in bits.
- BEATS, 4, beats per line; must equal LINE_W/BEAT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- dfp_addr  in  32  line address from cache; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  write line; must be stable while dfp_write is high
- dfp_rdata  out  256  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, always {addr[31:5],5'b0}
- bmem_read  out  1  read command, single cycle
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts a command/beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  returning read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst==0):
  - state=IDLE, beat counter=0, dfp_resp=0, bmem_read=0, bmem_write=0.
  - bmem_addr, bmem_wdata and dfp_rdata all reset to 0.
  - Any in-flight transaction is abandoned. No resp is generated for it.
- State machine is IDLE, RD_ISSUE, RD_COLLECT, WR_BURST, RESP.
- IDLE:
  - Captures {dfp_addr[31:5],5'b0} into an address register.
  - dfp_write=1 → WR_BURST, latching dfp_wdata into a line register. Write has priority if both requests are high; that case is illegal and is flagged by a bench assertion.
  - Else dfp_read=1 → RD_ISSUE.
  - Else stay in IDLE.
- RD_ISSUE:
  - bmem_read=1 and bmem_addr=saved address.
  - Advances to RD_COLLECT on the cycle bmem_ready=1.
  - bmem_read is high for exactly one ready cycle per line.
- RD_COLLECT:
  - A beat is consumed when bmem_rvalid=1 and bmem_raddr==saved address.
  - Beat k fills dfp_rdata[k*64 +: 64]; the counter increments modulo BEATS.
  - Beats may arrive non-consecutively. rvalid with a mismatched raddr is ignored.
  - On beat BEATS-1 → RESP.
- WR_BURST:
  - bmem_write=1, bmem_addr=saved address, bmem_wdata=line[cnt*64 +: 64].
  - cnt advances only on cycles where bmem_ready=1.
  - When beat BEATS-1 is accepted → RESP.
  - bmem_write=0 during ready-low stalls is not allowed: write holds beat data until accepted.
- RESP:
  - dfp_resp=1 for exactly one cycle. dfp_rdata holds the line (read) and is unchanged in later cycles until the next read fills it.
  - Next state is IDLE. The cache deasserts its request the cycle after resp, so IDLE never re-samples the completed request.
- Latency:
  - Read: dfp_resp asserts 1 cycle after the 4th valid beat; 2 cycles from request at minimum + memory latency.
  - Write: dfp_resp asserts 1 cycle after the 4th accepted beat.
  - Minimum write is 6 cycles from dfp_write rising with ready tied high.
- Outside RD_COLLECT, rvalid is ignored. The counter wraps to 0 on leaving each burst.
- A back-to-back dirty eviction followed by a refill is two independent transactions, separated by one IDLE cycle.

Decomposition:
- Shared package mem_types:
  - adapter_state_t enum.
  - LINE_W, BEAT_W and BEATS constants.
  - line_t and beat_t typedefs.
  - Helper constant for the line offset width (5).
- One natural sub-module, line_shift_buffer: a 256-bit register with a beat-indexed write port (read fill) and a beat-indexed read mux (write drain), sharing the counter from the FSM.

Test Plan:
- Read, ready=1, 4 consecutive rvalid beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at addr 0x0000_1234 → bmem_addr=0x0000_1220 and one bmem_read pulse. Then dfp_rdata={44..,33..,22..,11..} and dfp_resp pulses exactly once, 1 cycle after the 4th beat.
- Read with gaps of 0–3 idle cycles between beats, plus an interleaved rvalid with raddr=0xDEAD_0000 → stray beat ignored, line identical to the gap-free case.
- Write line 0xAAAA..._0000_0001 (beat0=0x…0001) with bmem_ready low on cycles 2 and 4 → 4 beats emitted in order. Each beat is held through the stall, and dfp_resp fires once after the 4th accepted beat.
- Write immediately followed by a read (eviction + refill) → two separate bursts with distinct addresses and two resp pulses. No duplicate bmem_read after the read's resp.
- rst driven to 0 in the middle of the 2nd beat of a read, then released → all outputs 0, no dfp_resp, and a subsequent read completes normally.
- dfp_read and dfp_write both high → write burst executes and the assertion fires.
